// File: rtl/bytecode_fetch_pkg.sv
// rtl/bytecode_fetch_pkg.sv - shared constants and FSM encoding for the bytecode fetch unit
package bytecode_fetch_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/bytecode_byte_fifo.sv
// rtl/bytecode_byte_fifo.sv - 8x8 byte FIFO taking 0..4 bytes per push, single pop, flush
module bytecode_byte_fifo
  import bytecode_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [2:0]  push_count,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [7:0]  head,
  output logic [3:0]  count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // push_data byte 0 lands at wr_ptr; caller guarantees room for push_count bytes
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (i < int'(push_count)) mem[wr_ptr + PTR_W'(i)] <= push_data[8*i +: 8];
      end
      wr_ptr <= wr_ptr + PTR_W'(push_count);
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + 4'(push_count) - 4'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bytecode_fetch.sv
// rtl/bytecode_fetch.sv - word-fetching bytecode prefetcher feeding a byte stream consumer
module bytecode_fetch
  import bytecode_fetch_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic [7:0]               byte_out,
  output logic [ADDRESS_WIDTH-1:0] byte_pc,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_rwn,
  output logic                     mem_start,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_data
);

  fetch_state_t             state, state_next;
  logic [ADDRESS_WIDTH-1:0] fetch_addr, fetch_addr_next;
  logic [ADDRESS_WIDTH-1:0] fetch_word_addr;
  logic                     discard, discard_next;
  logic [2:0]               push_count;
  logic [31:0]              push_data;
  logic [3:0]               fifo_count;
  logic                     pop;

  assign fetch_word_addr = {fetch_addr[ADDRESS_WIDTH-1:2], 2'b00};
  assign byte_valid      = (fifo_count != 4'd0);
  assign pop             = byte_valid && byte_ready && !redirect;
  assign mem_rwn         = 1'b1;

  // Only the first word after a restart is unaligned; its leading bytes are shifted out
  assign push_data = mem_data >> {fetch_addr[1:0], 3'b000};

  always_comb begin
    state_next      = state;
    discard_next    = discard;
    fetch_addr_next = fetch_addr;
    push_count      = 3'd0;
    mem_start       = 1'b0;
    mem_address     = '0;
    case (state)
      ST_IDLE: begin
        if (redirect || fifo_count <= 4'(FIFO_DEPTH - WORD_BYTES)) state_next = ST_REQ;
      end
      ST_REQ: begin
        mem_start   = 1'b1;
        mem_address = fetch_word_addr;
        if (mem_ready) begin
          state_next = ST_WAIT;
          if (redirect) discard_next = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_next   = ST_IDLE;
          discard_next = 1'b0;
          if (!discard && !redirect) begin
            push_count      = 3'(WORD_BYTES) - {1'b0, fetch_addr[1:0]};
            fetch_addr_next = fetch_word_addr + ADDRESS_WIDTH'(WORD_BYTES);
          end
        end else if (redirect) begin
          discard_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (redirect) fetch_addr_next = redirect_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      discard    <= 1'b0;
      fetch_addr <= RESET_PC;
      byte_pc    <= RESET_PC;
    end else begin
      state      <= state_next;
      discard    <= discard_next;
      fetch_addr <= fetch_addr_next;
      if (redirect) byte_pc <= redirect_pc;
      else if (pop) byte_pc <= byte_pc + 1'b1;
    end
  end

  bytecode_byte_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push_count (push_count),
    .push_data  (push_data),
    .pop        (pop),
    .head       (byte_out),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_bytecode_fetch.sv
// tb/tb_bytecode_fetch.sv - directed plus randomized bench for bytecode_fetch against a byte-stream model
module tb_bytecode_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic [7:0]  byte_out;
  logic [7:0]  byte_pc;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic [7:0]  mem_address;
  logic        mem_rwn;
  logic        mem_start;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_data = 32'h0;

  int          total = 0;
  int          passed = 0;
  int          failed = 0;
  logic [7:0]  exp_pc = 8'h00;
  int          pops = 0;
  int          strobes = 0;
  logic        accept_pending = 1'b0;
  int          mem_phase = 0;
  logic [7:0]  lat_addr = 8'h00;
  logic [7:0]  addr_log[$];
  logic        found;

  bytecode_fetch #(.ADDRESS_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .byte_out    (byte_out),
    .byte_pc     (byte_pc),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .mem_address (mem_address),
    .mem_rwn     (mem_rwn),
    .mem_start   (mem_start),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data)
  );

  always #5 clk = ~clk;

  // Memory image: byte at address i holds value i
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    logic [7:0] b;
    mem_word = 32'h0;
    for (int k = 0; k < 4; k++) begin
      b = a + 8'(k);
      mem_word[8*k +: 8] = b;
    end
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < addr_log.size()) return 32'(addr_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // Memory responder: accept while idle, one busy cycle, then return data
  initial forever begin
    @(negedge clk);
    if (reset && mem_start && mem_ready) begin
      accept_pending = 1'b1;
      lat_addr = mem_address;
      addr_log.push_back(mem_address);
      strobes++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (!reset) begin
      accept_pending = 1'b0;
      mem_phase = 0;
      mem_ready = 1'b1;
    end else if (accept_pending) begin
      accept_pending = 1'b0;
      mem_ready = 1'b0;
      mem_phase = 1;
    end else if (mem_phase == 1) begin
      mem_ready = 1'b1;
      mem_data = mem_word(lat_addr);
      mem_phase = 2;
    end else begin
      mem_phase = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, entered and left at a falling edge
  task automatic cycle(input logic rdy, input logic redir, input logic [7:0] rpc);
    byte_ready = rdy;
    redirect = redir;
    redirect_pc = rpc;
    if (redir) begin
      exp_pc = rpc;
    end else if (byte_valid && rdy) begin
      check("pop_byte", 32'(byte_out), 32'(exp_pc));
      check("pop_pc", 32'(byte_pc), 32'(exp_pc));
      exp_pc = exp_pc + 8'd1;
      pops++;
    end
    @(negedge clk);
    redirect = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_start", 32'(mem_start), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_out", 32'(byte_out), 32'd0);
    check("rst_pc", 32'(byte_pc), 32'd0);
    check("rst_rwn", 32'(mem_rwn), 32'd1);

    exp_pc = 8'h00;
    strobes = 0;
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 1'b0, 8'h00);
      if (k == 3) check("first_valid_early", 32'(byte_valid), 32'd0);
      if (k == 4) check("first_valid", 32'(byte_valid), 32'd1);
    end
    check("stall_strobes", 32'(strobes), 32'd2);
    check("stall_head", 32'(byte_out), 32'd0);
    repeat (10) cycle(1'b0, 1'b0, 8'h00);
    check("stall_no_more", 32'(strobes), 32'd2);

    pops = 0;
    repeat (30) cycle(1'b1, 1'b0, 8'h00);
    check("stream_progress", 32'(pops >= 12), 32'd1);

    repeat (20) cycle(1'b0, 1'b0, 8'h00);
    addr_log.delete();
    pops = 0;
    cycle(1'b0, 1'b1, 8'h06);
    check("redir_start", 32'(mem_start), 32'd1);
    check("redir_addr", 32'(mem_address), 32'h04);
    repeat (20) cycle(1'b1, 1'b0, 8'h00);
    check("unaligned_addr0", log_at(0), 32'h04);
    check("unaligned_addr1", log_at(1), 32'h08);
    check("unaligned_pops", 32'(pops >= 3), 32'd1);

    repeat (20) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h40);
    check("t1_start", 32'(mem_start), 32'd1);
    check("t1_valid", 32'(byte_valid), 32'd0);
    cycle(1'b0, 1'b0, 8'h00);
    check("t2_valid", 32'(byte_valid), 32'd0);
    cycle(1'b0, 1'b0, 8'h00);
    check("t3_valid", 32'(byte_valid), 32'd0);
    cycle(1'b0, 1'b0, 8'h00);
    check("t4_valid", 32'(byte_valid), 32'd1);
    check("t4_byte", 32'(byte_out), 32'h40);
    check("t4_pc", 32'(byte_pc), 32'h40);
    repeat (10) cycle(1'b1, 1'b0, 8'h00);

    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (mem_phase == 1) found = 1'b1;
      else cycle(1'b1, 1'b0, 8'h00);
    end
    check("wait_found", 32'(found), 32'd1);
    cycle(1'b1, 1'b1, 8'h40);
    check("wait_redir_flush", 32'(byte_valid), 32'd0);
    pops = 0;
    repeat (20) cycle(1'b1, 1'b0, 8'h00);
    check("wait_redir_pops", 32'(pops >= 4), 32'd1);

    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (mem_phase == 2) found = 1'b1;
      else cycle(1'b1, 1'b0, 8'h00);
    end
    check("return_found", 32'(found), 32'd1);
    cycle(1'b1, 1'b1, 8'h20);
    pops = 0;
    repeat (20) cycle(1'b1, 1'b0, 8'h00);
    check("return_redir_pops", 32'(pops >= 4), 32'd1);

    repeat (20) cycle(1'b0, 1'b0, 8'h00);
    addr_log.delete();
    pops = 0;
    cycle(1'b0, 1'b1, 8'hFC);
    repeat (20) cycle(1'b1, 1'b0, 8'h00);
    check("wrap_addr0", log_at(0), 32'hFC);
    check("wrap_addr1", log_at(1), 32'h00);
    check("wrap_pops", 32'(pops >= 5), 32'd1);

    repeat (300) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));
    end

    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (mem_phase == 1) found = 1'b1;
      else cycle(1'b1, 1'b0, 8'h00);
    end
    check("rst_wait_found", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(byte_valid), 32'd0);
    check("mid_rst_start", 32'(mem_start), 32'd0);
    check("mid_rst_addr", 32'(mem_address), 32'd0);
    check("mid_rst_pc", 32'(byte_pc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    exp_pc = 8'h00;
    addr_log.delete();
    pops = 0;
    reset = 1'b1;
    repeat (20) cycle(1'b1, 1'b0, 8'h00);
    check("restart_addr0", log_at(0), 32'h00);
    check("restart_pops", 32'(pops >= 8), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bytecode_fetch.md
BYTECODE_FETCH -- requirements
Module: bytecode_fetch

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, byte-address width shared with the memory.
REQ-002 SHALL have parameter RESET_PC, default 0, fetch start address after reset.
REQ-003 SHALL have input clk, 1 bit: clock; all state changes on rising edge.
REQ-004 SHALL have input reset, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have input redirect, 1 bit: flush and restart fetch at redirect_pc.
REQ-006 SHALL have input redirect_pc, ADDRESS_WIDTH bits: new bytecode PC.
REQ-007 SHALL have output byte_out, 8 bits: current bytecode byte.
REQ-008 SHALL have output byte_pc, ADDRESS_WIDTH bits: address of byte_out.
REQ-009 SHALL have output byte_valid, 1 bit: byte_out/byte_pc valid.
REQ-010 SHALL have input byte_ready, 1 bit: consumer accepts byte.
REQ-011 SHALL have output mem_address, ADDRESS_WIDTH bits: word-aligned read address.
REQ-012 SHALL have output mem_rwn, 1 bit: constant 1 (read only).
REQ-013 SHALL have output mem_start, 1 bit: memory request strobe.
REQ-014 SHALL have input mem_ready, 1 bit: memory idle/done.
REQ-015 SHALL have input mem_data, 32 bits: little-endian word; byte k = bits 8k+7:8k.

Function
REQ-016 SHALL contain an 8-byte FIFO; byte_valid = FIFO non-empty; byte_out/byte_pc = FIFO head.
REQ-017 SHALL pop when byte_valid && byte_ready; push and pop in same cycle SHALL both take effect.
REQ-018 SHALL implement FSM IDLE, REQ, WAIT.
REQ-019 IDLE->REQ when free space >= 4 and fetch enabled; else stay IDLE.
REQ-020 REQ: mem_start=1, mem_address = fetch_addr with bits [1:0] = 0; REQ->WAIT on mem_start && mem_ready; mem_start held while mem_ready=0.
REQ-021 WAIT: on mem_ready=1 capture mem_data, push bytes, fetch_addr += 4 modulo 2^ADDRESS_WIDTH, go IDLE.
REQ-022 First word after reset/redirect SHALL push only bytes pc[1:0]..3 (4-pc[1:0] bytes); later words push 4 bytes.
REQ-023 byte_pc SHALL increment by 1 per pop, modulo 2^ADDRESS_WIDTH.
REQ-024 Aligned-address timing: redirect in cycle N -> mem_start in N+1 -> mem_ready sampled high in N+3 -> byte_valid in N+4.
REQ-025 redirect SHALL empty FIFO, load fetch_addr and byte_pc from redirect_pc; a pop in the same cycle SHALL be ignored.
REQ-026 redirect in REQ (when accepted) or WAIT SHALL set discard; returned word SHALL be dropped, not pushed; FSM then proceeds normally with the new address.
REQ-027 redirect coinciding with data return SHALL drop that word.
REQ-028 At most one memory request SHALL be outstanding.

Reset
REQ-029 During reset: FSM=IDLE, FIFO empty, byte_valid=0, mem_start=0, mem_address=0, discard=0, fetch_addr=byte_pc=RESET_PC, byte_out=0.
REQ-030 After reset release fetch SHALL begin from RESET_PC without redirect.

Structure
REQ-031 Shared package SHALL hold FSM state encoding, FIFO_DEPTH=8 and WORD_BYTES=4.
REQ-032 FIFO SHALL be sub-module bytecode_byte_fifo (8x8, push-count 0..4, single pop, flush).

Verification (memory preloaded with byte[i]=i)
REQ-033 Reset release, byte_ready=1 -> bytes 0x00,0x01,0x02... with byte_pc=data; first byte_valid 4 cycles after release.
REQ-034 redirect_pc=0x06 -> mem_address 0x04 then 0x08; output 0x06,0x07,0x08 in order.
REQ-035 byte_ready=0 for 20 cycles from reset -> exactly 2 mem_start strobes, FIFO holds 8 bytes, no further requests.
REQ-036 redirect_pc=0x40 during WAIT -> in-flight word never appears; next byte 0x40 at byte_pc 0x40.
REQ-037 redirect_pc=0xFC -> bytes 0xFC..0xFF then 0x00; mem_address wraps to 0x00.
REQ-038 reset low during WAIT -> mem_start=0, byte_valid=0 immediately; after release fetch restarts at RESET_PC.
